// File: rtl/mem_bank_bridge.sv
// Bridges the ibex data and instruction ports onto banked 1RW1R SRAM macros,
// adding a gnt/rvalid handshake, window decode with error responses and a write/fetch hazard guard.
module mem_bank_bridge #(
   parameter int unsigned NUM_BANKS    = 4,
   parameter int unsigned BANK_AW      = 8,
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      data_req_i,
   output logic                      data_gnt_o,
   output logic                      data_rvalid_o,
   input  logic                      data_we_i,
   input  logic [3:0]                data_be_i,
   input  logic [31:0]               data_addr_i,
   input  logic [31:0]               data_wdata_i,
   output logic [31:0]               data_rdata_o,
   output logic                      data_err_o,
   input  logic                      instr_req_i,
   output logic                      instr_gnt_o,
   output logic                      instr_rvalid_o,
   input  logic [31:0]               instr_addr_i,
   output logic [31:0]               instr_rdata_o,
   output logic                      instr_err_o,
   output logic [NUM_BANKS-1:0]      sram_csb0_o,
   output logic                      sram_web0_o,
   output logic [3:0]                sram_wmask0_o,
   output logic [BANK_AW-1:0]        sram_addr0_o,
   output logic [31:0]               sram_din0_o,
   input  logic [32*NUM_BANKS-1:0]   sram_dout0_i,
   output logic [NUM_BANKS-1:0]      sram_csb1_o,
   output logic [BANK_AW-1:0]        sram_addr1_o,
   input  logic [32*NUM_BANKS-1:0]   sram_dout1_i
);

   localparam int unsigned BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int unsigned LOG2_NB = $clog2(NUM_BANKS);
   localparam int unsigned WIN_LSB = BANK_AW + 2 + LOG2_NB;
   localparam logic [1:0]  CNT_INIT = 2'(READ_LATENCY);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // Address decode, shared rule for both ports
   logic [31:0]        d_off;
   logic [31:0]        i_off;
   logic [BANK_AW-1:0] d_word;
   logic [BANK_AW-1:0] i_word;
   logic [BANK_W-1:0]  d_bank;
   logic [BANK_W-1:0]  i_bank;
   logic               d_inwin;
   logic               i_inwin;

   assign d_off   = data_addr_i - BASE_ADDR;
   assign i_off   = instr_addr_i - BASE_ADDR;
   assign d_word  = d_off[BANK_AW+1:2];
   assign i_word  = i_off[BANK_AW+1:2];
   assign d_bank  = BANK_W'((d_off >> (BANK_AW + 2)) & (NUM_BANKS - 1));
   assign i_bank  = BANK_W'((i_off >> (BANK_AW + 2)) & (NUM_BANKS - 1));
   assign d_inwin = ((d_off >> WIN_LSB) == 32'd0);
   assign i_inwin = ((i_off >> WIN_LSB) == 32'd0);

   // Data port FSM
   logic [0:0]        d_state;
   logic [1:0]        d_cnt;
   logic              d_err_q;
   logic              d_wr_q;
   logic [BANK_W-1:0] d_bank_q;
   logic              d_ready;
   logic [31:0]       d_dout;

   assign data_rvalid_o = (d_state == ST_BUSY) && (d_cnt == 2'd1);
   assign d_ready       = (d_state == ST_IDLE) || data_rvalid_o;
   assign data_gnt_o    = resetn && data_req_i && d_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         d_state  <= ST_IDLE;
         d_cnt    <= 2'd0;
         d_err_q  <= 1'b0;
         d_wr_q   <= 1'b0;
         d_bank_q <= '0;
      end else if (data_gnt_o) begin
         d_state  <= ST_BUSY;
         d_cnt    <= CNT_INIT;
         d_err_q  <= ~d_inwin;
         d_wr_q   <= data_we_i;
         d_bank_q <= d_bank;
      end else if (d_state == ST_BUSY) begin
         d_cnt <= d_cnt - 2'd1;
         if (d_cnt == 2'd1) d_state <= ST_IDLE;
      end
   end

   // A fetch of the exact word being written this cycle would read stale data
   logic hazard;
   assign hazard = data_gnt_o && data_we_i && d_inwin && i_inwin &&
                   (d_bank == i_bank) && (d_word == i_word);

   // Instruction port FSM
   logic [0:0]        i_state;
   logic [1:0]        i_cnt;
   logic              i_err_q;
   logic [BANK_W-1:0] i_bank_q;
   logic              i_ready;
   logic [31:0]       i_dout;

   assign instr_rvalid_o = (i_state == ST_BUSY) && (i_cnt == 2'd1);
   assign i_ready        = (i_state == ST_IDLE) || instr_rvalid_o;
   assign instr_gnt_o    = resetn && instr_req_i && i_ready && !hazard;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         i_state  <= ST_IDLE;
         i_cnt    <= 2'd0;
         i_err_q  <= 1'b0;
         i_bank_q <= '0;
      end else if (instr_gnt_o) begin
         i_state  <= ST_BUSY;
         i_cnt    <= CNT_INIT;
         i_err_q  <= ~i_inwin;
         i_bank_q <= i_bank;
      end else if (i_state == ST_BUSY) begin
         i_cnt <= i_cnt - 2'd1;
         if (i_cnt == 2'd1) i_state <= ST_IDLE;
      end
   end

   // Response data muxes, selected by the bank captured at grant
   always_comb begin
      d_dout = '0;
      i_dout = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (d_bank_q == BANK_W'(b)) d_dout = sram_dout0_i[32*b +: 32];
         if (i_bank_q == BANK_W'(b)) i_dout = sram_dout1_i[32*b +: 32];
      end
   end

   assign data_rdata_o  = (data_rvalid_o && !d_err_q && !d_wr_q) ? d_dout : 32'd0;
   assign data_err_o    = data_rvalid_o && d_err_q;
   assign instr_rdata_o = (instr_rvalid_o && !i_err_q) ? i_dout : 32'd0;
   assign instr_err_o   = instr_rvalid_o && i_err_q;

   // Macro side: chip selects only on granted in-window accesses
   always_comb begin
      sram_csb0_o = '1;
      sram_csb1_o = '1;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (data_gnt_o && d_inwin && (d_bank == BANK_W'(b))) sram_csb0_o[b] = 1'b0;
         if (instr_gnt_o && i_inwin && (i_bank == BANK_W'(b))) sram_csb1_o[b] = 1'b0;
      end
   end

   assign sram_web0_o   = resetn ? ~data_we_i : 1'b1;
   assign sram_wmask0_o = resetn ? data_be_i : 4'd0;
   assign sram_addr0_o  = resetn ? d_word : '0;
   assign sram_din0_o   = resetn ? data_wdata_i : 32'd0;
   assign sram_addr1_o  = resetn ? i_word : '0;

endmodule

// File: tb/tb_mem_bank_bridge.sv
// Bench for mem_bank_bridge: an L=1 instance under directed and random traffic against a flat
// reference memory, and an L=2 instance for throughput and mid-transfer reset.
module tb_mem_bank_bridge;

   localparam int          NB    = 4;
   localparam int          AW    = 8;
   localparam int          WIN   = NB * (1 << AW) * 4;
   localparam logic [31:0] BASE1 = 32'h0000_0000;
   localparam logic [31:0] BASE2 = 32'h8000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resetn, resetn2;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Instance 1 (READ_LATENCY = 1)
   logic        d_req, d_gnt, d_rvalid, d_we, d_err;
   logic [3:0]  d_be;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        i_req, i_gnt, i_rvalid, i_err;
   logic [31:0] i_addr, i_rdata;
   logic [NB-1:0]   csb0, csb1;
   logic            web0;
   logic [3:0]      wmask0;
   logic [AW-1:0]   addr0, addr1;
   logic [31:0]     din0;
   logic [32*NB-1:0] dout0, dout1;

   mem_bank_bridge #(.NUM_BANKS(NB), .BANK_AW(AW), .READ_LATENCY(1), .BASE_ADDR(BASE1)) u_dut1 (
      .clk(clk), .resetn(resetn),
      .data_req_i(d_req), .data_gnt_o(d_gnt), .data_rvalid_o(d_rvalid), .data_we_i(d_we),
      .data_be_i(d_be), .data_addr_i(d_addr), .data_wdata_i(d_wdata), .data_rdata_o(d_rdata),
      .data_err_o(d_err),
      .instr_req_i(i_req), .instr_gnt_o(i_gnt), .instr_rvalid_o(i_rvalid), .instr_addr_i(i_addr),
      .instr_rdata_o(i_rdata), .instr_err_o(i_err),
      .sram_csb0_o(csb0), .sram_web0_o(web0), .sram_wmask0_o(wmask0), .sram_addr0_o(addr0),
      .sram_din0_o(din0), .sram_dout0_i(dout0),
      .sram_csb1_o(csb1), .sram_addr1_o(addr1), .sram_dout1_i(dout1)
   );

   // Instance 2 (READ_LATENCY = 2), data port only
   logic        b_req, b_gnt, b_rvalid, b_err;
   logic [31:0] b_addr, b_rdata;
   logic        b_igod, b_irv, b_ierr;
   logic [31:0] b_irdata;
   logic [NB-1:0]    b_csb0, b_csb1;
   logic             b_web0;
   logic [3:0]       b_wmask0;
   logic [AW-1:0]    b_addr0, b_addr1;
   logic [31:0]      b_din0;
   logic [32*NB-1:0] b_dout0;

   mem_bank_bridge #(.NUM_BANKS(NB), .BANK_AW(AW), .READ_LATENCY(2), .BASE_ADDR(BASE2)) u_dut2 (
      .clk(clk), .resetn(resetn2),
      .data_req_i(b_req), .data_gnt_o(b_gnt), .data_rvalid_o(b_rvalid), .data_we_i(1'b0),
      .data_be_i(4'hF), .data_addr_i(b_addr), .data_wdata_i(32'd0), .data_rdata_o(b_rdata),
      .data_err_o(b_err),
      .instr_req_i(1'b0), .instr_gnt_o(b_igod), .instr_rvalid_o(b_irv), .instr_addr_i(32'd0),
      .instr_rdata_o(b_irdata), .instr_err_o(b_ierr),
      .sram_csb0_o(b_csb0), .sram_web0_o(b_web0), .sram_wmask0_o(b_wmask0), .sram_addr0_o(b_addr0),
      .sram_din0_o(b_din0), .sram_dout0_i(b_dout0),
      .sram_csb1_o(b_csb1), .sram_addr1_o(b_addr1), .sram_dout1_i({(32*NB){1'b0}})
   );

   // Banked macro models
   logic [31:0] m1 [NB][1 << AW];
   logic [31:0] q0 [NB];
   logic [31:0] q1 [NB];
   logic [31:0] s1 [NB];
   logic [31:0] s2 [NB];

   function automatic logic [31:0] init_val(input int idx);
      return 32'(idx) * 32'h9E37_79B1 ^ 32'h5A5A_5A5A;
   endfunction

   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (!csb0[b]) begin
            if (!web0) begin
               for (int k = 0; k < 4; k++)
                  if (wmask0[k]) m1[b][addr0][8*k +: 8] <= din0[8*k +: 8];
            end else begin
               q0[b] <= m1[b][addr0];
            end
         end
         if (!csb1[b]) q1[b] <= m1[b][addr1];
         if (!b_csb0[b] && b_web0) s1[b] <= 32'hC0DE_0000 + 32'(b * 256) + 32'(b_addr0);
         s2[b] <= s1[b];
      end
   end

   always_comb begin
      dout0   = '0;
      dout1   = '0;
      b_dout0 = '0;
      for (int b = 0; b < NB; b++) begin
         dout0[32*b +: 32]   = q0[b];
         dout1[32*b +: 32]   = q1[b];
         b_dout0[32*b +: 32] = s2[b];
      end
   end

   // Reference model: flat word memory plus per-port next-accept cycle
   logic [31:0] ref_mem [WIN/4];
   int          d_next = 0;
   int          i_next = 0;
   int          b_next = 0;
   logic [64:0] exp_d_q [$];
   logic [64:0] exp_i_q [$];
   logic [64:0] exp_b_q [$];

   initial begin
      for (int idx = 0; idx < WIN / 4; idx++) begin
         m1[idx / (1 << AW)][idx % (1 << AW)] <= init_val(idx);
         ref_mem[idx] = init_val(idx);
      end
      for (int b = 0; b < NB; b++) begin
         q0[b] <= 32'd0; q1[b] <= 32'd0; s1[b] <= 32'd0; s2[b] <= 32'd0;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic resp_check(input string nm, input logic [64:0] e, input logic [31:0] rd,
                             input logic er);
      chk({nm, "_cycle"}, 64'(cyc), 64'(e[64:33]));
      chk({nm, "_err"}, 64'(er), 64'(e[32]));
      chk({nm, "_rdata"}, 64'(rd), 64'(e[31:0]));
   endtask

   // Monitors: pop and compare whenever a response is presented
   always @(negedge clk) begin
      if (resetn) begin
         if (d_rvalid) begin
            if (exp_d_q.size() == 0) chk("data_rvalid_unexpected", 64'(d_rvalid), 64'd0);
            else resp_check("data_resp", exp_d_q.pop_front(), d_rdata, d_err);
         end else begin
            chk("data_idle_out", {31'd0, d_err, d_rdata}, 64'd0);
         end
         if (i_rvalid) begin
            if (exp_i_q.size() == 0) chk("instr_rvalid_unexpected", 64'(i_rvalid), 64'd0);
            else resp_check("instr_resp", exp_i_q.pop_front(), i_rdata, i_err);
         end else begin
            chk("instr_idle_out", {31'd0, i_err, i_rdata}, 64'd0);
         end
      end
      if (resetn2) begin
         if (b_rvalid) begin
            if (exp_b_q.size() == 0) chk("l2_rvalid_unexpected", 64'(b_rvalid), 64'd0);
            else resp_check("l2_resp", exp_b_q.pop_front(), b_rdata, b_err);
         end else begin
            chk("l2_idle_out", {31'd0, b_err, b_rdata}, 64'd0);
         end
      end
   end

   // One cycle on instance 1: drive, then check grants and macro strobes against the model
   task automatic do_cycle(input logic dr, input logic dw, input logic [3:0] be,
                           input logic [31:0] da, input logic [31:0] dwd,
                           input logic ir, input logic [31:0] ia);
      logic [31:0] doff, ioff;
      logic        dinw, iinw, eg_d, eg_i, haz;
      logic [3:0]  ecsb0, ecsb1;
      int          didx, iidx;
      @(negedge clk);
      d_req = dr; d_we = dw; d_be = be; d_addr = da; d_wdata = dwd;
      i_req = ir; i_addr = ia;
      #4;
      doff = da - BASE1;
      ioff = ia - BASE1;
      dinw = doff < 32'(WIN);
      iinw = ioff < 32'(WIN);
      didx = int'(doff / 4);
      iidx = int'(ioff / 4);
      eg_d = dr && (cyc >= d_next);
      haz  = eg_d && dw && dinw && iinw && (didx == iidx);
      eg_i = ir && (cyc >= i_next) && !haz;
      chk("data_gnt", 64'(d_gnt), 64'(eg_d));
      chk("instr_gnt", 64'(i_gnt), 64'(eg_i));
      ecsb0 = 4'hF;
      ecsb1 = 4'hF;
      if (eg_d && dinw) ecsb0[doff / 1024] = 1'b0;
      if (eg_i && iinw) ecsb1[ioff / 1024] = 1'b0;
      chk("csb0", 64'(csb0), 64'(ecsb0));
      chk("csb1", 64'(csb1), 64'(ecsb1));
      if (eg_d) begin
         chk("addr0", 64'(addr0), 64'(didx % 256));
         chk("web0", 64'(web0), 64'(!dw));
         chk("wmask0", 64'(wmask0), 64'(be));
         chk("din0", 64'(din0), 64'(dwd));
         d_next = cyc + 1;
         if (!dinw) exp_d_q.push_back({32'(cyc + 1), 1'b1, 32'd0});
         else if (dw) begin
            for (int k = 0; k < 4; k++)
               if (be[k]) ref_mem[didx][8*k +: 8] = dwd[8*k +: 8];
            exp_d_q.push_back({32'(cyc + 1), 1'b0, 32'd0});
         end else exp_d_q.push_back({32'(cyc + 1), 1'b0, ref_mem[didx]});
      end
      if (eg_i) begin
         chk("addr1", 64'(addr1), 64'(iidx % 256));
         i_next = cyc + 1;
         if (!iinw) exp_i_q.push_back({32'(cyc + 1), 1'b1, 32'd0});
         else exp_i_q.push_back({32'(cyc + 1), 1'b0, ref_mem[iidx]});
      end
   endtask

   // One cycle on instance 2
   task automatic b_cycle(input logic r, input logic [31:0] a);
      logic [31:0] off;
      logic        eg;
      @(negedge clk);
      b_req = r; b_addr = a;
      #4;
      off = a - BASE2;
      eg  = r && (cyc >= b_next);
      chk("l2_gnt", 64'(b_gnt), 64'(eg));
      if (eg) begin
         b_next = cyc + 2;
         if (off >= 32'(WIN)) exp_b_q.push_back({32'(cyc + 2), 1'b1, 32'd0});
         else exp_b_q.push_back({32'(cyc + 2), 1'b0, 32'hC0DE_0000 + off / 4});
      end
   endtask

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 9) == 0) return BASE1 + 32'(WIN) + 32'($urandom_range(0, 4095));
      return BASE1 + 32'($urandom_range(0, 3) * 1024 + $urandom_range(0, 3) * 4 +
                         $urandom_range(0, 3));
   endfunction

   logic [31:0] l2_addrs [4];

   initial begin
      resetn = 1'b0; resetn2 = 1'b0;
      d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h404; d_wdata = 32'hFFFF_FFFF;
      i_req = 1'b1; i_addr = 32'h404;
      b_req = 1'b1; b_addr = BASE2;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_data_gnt", 64'(d_gnt), 64'd0);
      chk("rst_instr_gnt", 64'(i_gnt), 64'd0);
      chk("rst_rvalid", {62'd0, d_rvalid, i_rvalid}, 64'd0);
      chk("rst_rdata", {d_rdata, i_rdata}, 64'd0);
      chk("rst_err", {62'd0, d_err, i_err}, 64'd0);
      chk("rst_csb", {56'd0, csb0, csb1}, 64'hFF);
      chk("rst_web0", 64'(web0), 64'd1);
      chk("rst_addr_mask", {44'd0, addr0, addr1, wmask0}, 64'd0);
      chk("rst_din0", 64'(din0), 64'd0);
      chk("rst_l2_gnt", 64'(b_gnt), 64'd0);

      @(negedge clk);
      resetn = 1'b1; resetn2 = 1'b1;
      d_req = 1'b0; i_req = 1'b0; b_req = 1'b0;

      // Directed traffic
      do_cycle(1, 1, 4'hF, 32'h0000_0404, 32'hDEAD_BEEF, 0, 32'h0);
      do_cycle(1, 0, 4'hF, 32'h0000_0404, 32'h0, 0, 32'h0);
      do_cycle(1, 1, 4'b0101, 32'h0000_0808, 32'h1122_3344, 0, 32'h0);
      do_cycle(1, 0, 4'hF, 32'h0000_0808, 32'h0, 0, 32'h0);
      do_cycle(1, 0, 4'hF, 32'h0000_0C08, 32'h0, 0, 32'h0);
      do_cycle(1, 0, 4'hF, 32'h0000_1000, 32'h0, 0, 32'h0);
      do_cycle(1, 1, 4'hF, 32'h0000_0020, 32'hCAFE_F00D, 1, 32'h0000_0020);
      do_cycle(0, 0, 4'hF, 32'h0, 32'h0, 1, 32'h0000_0020);
      do_cycle(1, 0, 4'hF, 32'h0000_0020, 32'h0, 1, 32'h0000_0022);
      do_cycle(0, 0, 4'hF, 32'h0, 32'h0, 1, 32'h0000_2000);

      // Randomised traffic on a small address set so hazards are frequent
      for (int n = 0; n < 400; n++)
         do_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  rand_addr(), $urandom(), $urandom_range(0, 3) != 0, rand_addr());
      repeat (4) do_cycle(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0);
      chk("data_queue_drained", 64'(exp_d_q.size()), 64'd0);
      chk("instr_queue_drained", 64'(exp_i_q.size()), 64'd0);

      // L=2: request held across four reads
      l2_addrs[0] = BASE2 + 32'h0000_0C08;
      l2_addrs[1] = BASE2 + 32'h0000_0004;
      l2_addrs[2] = BASE2 - 32'h0000_0010;
      l2_addrs[3] = BASE2 + 32'h0000_07FC;
      for (int k = 0; k < 8; k++) begin
         b_cycle(1, l2_addrs[k / 2]);
         if (k == 0) chk("l2_csb0", 64'(b_csb0), 64'h7);
      end
      repeat (3) b_cycle(0, BASE2);

      // Reset one cycle after an L=2 grant: the response must never appear
      b_cycle(1, BASE2 + 32'h10);
      @(negedge clk);
      resetn2 = 1'b0;
      exp_b_q.delete();
      b_next = 0;
      #1;
      chk("l2_rst_gnt", 64'(b_gnt), 64'd0);
      chk("l2_rst_rvalid", 64'(b_rvalid), 64'd0);
      chk("l2_rst_csb0", 64'(b_csb0), 64'hF);
      chk("l2_rst_web0_addr", {55'd0, b_web0, b_addr0}, {55'd0, 1'b1, 8'd0});
      repeat (2) @(negedge clk);
      b_req = 1'b0;
      resetn2 = 1'b1;
      repeat (4) b_cycle(0, BASE2);
      b_cycle(1, BASE2 + 32'h44);
      repeat (4) b_cycle(0, BASE2);
      chk("l2_queue_drained", 64'(exp_b_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
